led_cmd_parser: RTL

Byte-stream command decoder that sits directly downstream of the UART receiver. It consumes the receiver's `valid`/`data` byte strobe, parses short ASCII commands of the form `L<n><v><EOL>`, and drives a registered LED vector for the board LEDs. Malformed or stalled commands are discarded, and each discard is flagged with an error pulse.

---
 rtl/led_cmd_pkg.sv | 35 +++
 rtl/cmd_idle_timer.sv | 33 +++
 rtl/led_cmd_parser.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/led_cmd_pkg.sv
// led_cmd_pkg: shared types and ASCII constants for the LED command parser.
//   state_t  : parser FSM states
//   led_op_t : latched LED operation (clear / set / toggle)
//   CH_*     : ASCII bytes recognised by the grammar and the ack echo
package led_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GOT_L,
    GOT_IDX,
    GOT_VAL,
    SKIP
  } state_t;

  typedef enum logic [1:0] {
    OP_CLR,
    OP_SET,
    OP_TOG
  } led_op_t;

  localparam logic [7:0] CH_L_UP    = 8'h4C;  // 'L'
  localparam logic [7:0] CH_L_LO    = 8'h6C;  // 'l'
  localparam logic [7:0] CH_CR      = 8'h0D;
  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_0       = 8'h30;  // '0'
  localparam logic [7:0] CH_1       = 8'h31;  // '1'
  localparam logic [7:0] CH_T       = 8'h54;  // 'T'
  localparam logic [7:0] CH_ACK_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] CH_ACK_ERR = 8'h45;  // 'E'

  function automatic logic is_eol(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

endpackage

// File: rtl/cmd_idle_timer.sv
// cmd_idle_timer: idle-cycle counter for an in-progress command.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : force the count to 0 (byte accepted, or parser not mid-command)
//   i_enable       : count one idle cycle
//   o_expired      : count has reached TIMEOUT_CYCLES (saturates there)
module cmd_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_200_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned     W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0]    LP_LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LP_LIMIT)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expired = (r_count == LP_LIMIT);

endmodule

// File: rtl/led_cmd_parser.sv
// led_cmd_parser: decodes "L<n><v><EOL>" byte commands from a UART receiver
// and drives a registered LED vector.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid/i_data : received byte strobe and byte
//   o_led          : LED state, bit 0 = LED1
//   o_cmd_strobe   : one-cycle pulse when a command is applied
//   o_err_strobe   : one-cycle pulse when a command is discarded
// Optional (macro LED_CMD_ECHO_EN):
//   o_ack_valid/o_ack_data : 'K' on apply, 'E' on error, for a UART transmitter
module led_cmd_parser
  import led_cmd_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1_200_000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [7:0]          i_data,
  output logic [NUM_LEDS-1:0] o_led,
  output logic                o_cmd_strobe,
  output logic                o_err_strobe
`ifdef LED_CMD_ECHO_EN
  ,
  output logic                o_ack_valid,
  output logic [7:0]          o_ack_data
`endif
);

  localparam logic [7:0]          LP_NUM = 8'(NUM_LEDS);
  localparam logic [NUM_LEDS-1:0] LP_ONE = NUM_LEDS'(1);

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_idx;
  led_op_t             r_op;
  logic [NUM_LEDS-1:0] r_led;
  logic                r_cmd_strobe;
  logic                r_err_strobe;

  logic [7:0]          w_diff;
  logic                w_idx_ok;
  logic                w_val_ok;
  led_op_t             w_op;
  logic                w_is_l;
  logic                w_is_eol;
  logic                w_mid_cmd;
  logic                w_expired;
  logic                w_cmd;
  logic                w_err;
  logic                w_latch_idx;
  logic                w_latch_val;
  logic [NUM_LEDS-1:0] w_mask;

  // Byte classification. The full 8-bit difference is compared so that '0'
  // (wraps to 0xFF) and non-digit bytes are rejected as indices.
  assign w_diff   = i_data - CH_1;
  assign w_idx_ok = (w_diff < LP_NUM);
  assign w_is_l   = (i_data == CH_L_UP) || (i_data == CH_L_LO);
  assign w_is_eol = is_eol(i_data);

  always_comb begin
    w_val_ok = 1'b1;
    w_op     = OP_CLR;
    case (i_data)
      CH_0:    w_op = OP_CLR;
      CH_1:    w_op = OP_SET;
      CH_T:    w_op = OP_TOG;
      default: w_val_ok = 1'b0;
    endcase
  end

  // Idle timer runs only while a command is partially received.
  assign w_mid_cmd = (r_state == GOT_L) || (r_state == GOT_IDX) || (r_state == GOT_VAL);

  cmd_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (!w_mid_cmd || i_valid),
    .i_enable (w_mid_cmd),
    .o_expired(w_expired)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic. A byte always takes priority over a timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_valid) begin
          if (w_is_l)        w_state_next = GOT_L;
          else if (w_is_eol) w_state_next = IDLE;
          else               w_state_next = SKIP;
        end
      end
      GOT_L: begin
        if (i_valid) begin
          if (w_idx_ok)      w_state_next = GOT_IDX;
          else if (w_is_eol) w_state_next = IDLE;
          else               w_state_next = SKIP;
        end else if (w_expired) begin
          w_state_next = IDLE;
        end
      end
      GOT_IDX: begin
        if (i_valid) begin
          if (w_val_ok)      w_state_next = GOT_VAL;
          else if (w_is_eol) w_state_next = IDLE;
          else               w_state_next = SKIP;
        end else if (w_expired) begin
          w_state_next = IDLE;
        end
      end
      GOT_VAL: begin
        if (i_valid) begin
          if (w_is_eol) w_state_next = IDLE;
          else          w_state_next = SKIP;
        end else if (w_expired) begin
          w_state_next = IDLE;
        end
      end
      SKIP: begin
        if (i_valid && w_is_eol) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode: apply/error events and field latch enables.
  always_comb begin
    w_cmd       = 1'b0;
    w_err       = 1'b0;
    w_latch_idx = 1'b0;
    w_latch_val = 1'b0;
    case (r_state)
      IDLE: begin
        w_err = i_valid && !w_is_l && !w_is_eol;
      end
      GOT_L: begin
        w_latch_idx = i_valid && w_idx_ok;
        w_err       = i_valid ? !w_idx_ok : w_expired;
      end
      GOT_IDX: begin
        w_latch_val = i_valid && w_val_ok;
        w_err       = i_valid ? !w_val_ok : w_expired;
      end
      GOT_VAL: begin
        w_cmd = i_valid && w_is_eol;
        w_err = i_valid ? !w_is_eol : w_expired;
      end
      default: begin
        w_cmd = 1'b0;
        w_err = 1'b0;
      end
    endcase
  end

  assign w_mask = LP_ONE << r_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx        <= '0;
      r_op         <= OP_CLR;
      r_led        <= '0;
      r_cmd_strobe <= 1'b0;
      r_err_strobe <= 1'b0;
    end else begin
      r_cmd_strobe <= w_cmd;
      r_err_strobe <= w_err;
      if (w_latch_idx) r_idx <= w_diff[3:0];
      if (w_latch_val) r_op  <= w_op;
      if (w_cmd) begin
        case (r_op)
          OP_CLR:  r_led <= r_led & ~w_mask;
          OP_SET:  r_led <= r_led | w_mask;
          OP_TOG:  r_led <= r_led ^ w_mask;
          default: r_led <= r_led;
        endcase
      end
    end
  end

  assign o_led        = r_led;
  assign o_cmd_strobe = r_cmd_strobe;
  assign o_err_strobe = r_err_strobe;

`ifdef LED_CMD_ECHO_EN
  logic       r_ack_valid;
  logic [7:0] r_ack_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack_valid <= 1'b0;
      r_ack_data  <= '0;
    end else begin
      r_ack_valid <= w_cmd || w_err;
      if (w_cmd)      r_ack_data <= CH_ACK_OK;
      else if (w_err) r_ack_data <= CH_ACK_ERR;
    end
  end

  assign o_ack_valid = r_ack_valid;
  assign o_ack_data  = r_ack_data;
`endif

endmodule
